instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage for the single-issue CPU. Owns the program counter, drives the word address into the synchronous instruction memory (which registers its read data one clock after sampling the address), and presents each returned instruction with its PC to the decode stage over a valid/ready handshake. Handles decode back-pressure by replaying the held address, handles control-flow redirects by flushing, and counts decode stall cycles.

## Interface
- ADDR_W, 6: instruction word address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 32: instruction width.
- RESET_PC, 0: first address fetched after reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset: when reset==0 at a rising edge of clk, all state is reset.
- imem_address  out  ADDR_W  address to instruction memory; combinational from state and inputs; sampled by memory at each rising edge.
- imem_data  in  DATA_W  memory read data; equals mem[address sampled at previous edge].
- redirect_valid  in  1  branch/jump taken; flush and refetch from redirect_target.
- redirect_target  in  ADDR_W  new PC.
- id_ready  in  1  decode can accept this cycle.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  DATA_W  fetched instruction (registered).
- if_pc  out  ADDR_W  address of if_instr (registered).
- stall_count  out  16  saturating count of cycles with if_valid && !id_ready.

## Operation
- State: pc_q (address whose data is on imem_data), rsp_valid (imem_data is valid for pc_q), output register (if_valid, if_instr, if_pc), stall_count.
- Reset values: pc_q=RESET_PC, rsp_valid=0, if_valid=0, if_instr=0, if_pc=0, stall_count=0. While reset==0, imem_address=RESET_PC.
- Transfer to decode occurs on any edge where if_valid && id_ready.
- load = rsp_valid && (!if_valid || id_ready) && !redirect_valid.
- Address selection, priority order:
  - redirect_valid: imem_address=redirect_target; at edge pc_q<=redirect_target, rsp_valid<=1, if_valid<=0 (flush; the instruction in the output register is dropped unless transferred that same edge).
  - !rsp_valid (first cycle after reset): imem_address=pc_q; at edge rsp_valid<=1.
  - rsp_valid && load: imem_address=pc_q+1 (wraps 2^ADDR_W-1 -> 0); at edge pc_q<=pc_q+1, if_instr<=imem_data, if_pc<=pc_q, if_valid<=1.
  - rsp_valid && !load (stalled): imem_address=pc_q (replay; memory re-reads same word); state held.
- Output register with no load and transfer: if_valid<=0. No load and no transfer: hold.
- stall_count increments when if_valid && !id_ready, saturates at 16'hFFFF; never cleared except by reset.
- Reset wins over redirect and handshake on the same edge.

## Timing
- Startup: first edge with reset==1 is E1; if_valid rises after E2 with if_pc=RESET_PC, if_instr=mem[RESET_PC].
- Steady state: one instruction per cycle while id_ready=1; no bubbles.
- Stall: if_* held stable and imem_address=pc_q every stalled cycle; on id_ready returning, next instruction appears after the following edge, no lost or duplicated PCs.
- Redirect asserted before edge Er: exactly one bubble (if_valid=0 after Er); after Er+1 if_pc=target, provided no second redirect.
- Back-to-back redirects: last one wins; if_valid stays 0 until one cycle after the final redirect.
- Redirect while stalled: flush applies; held instruction discarded.
- Wrap: PC 63 followed by PC 0 (ADDR_W=6), no gap.

## Test plan
- Startup, memory model mem[i]=32'hA000_0000+i, id_ready=1: after E2 if_pc=0, if_instr=32'hA000_0000; next 5 cycles if_pc=1..5 consecutively.
- Stall: hold id_ready=0 for 3 cycles while if_pc=4: if_pc/if_instr stay 4/32'hA000_0004, imem_address=5, stall_count=3; release -> if_pc=5 then 6.
- Redirect: redirect_valid=1, target=40 when if_pc=7: one cycle if_valid=0, then if_pc=40, 41; PC 8 never presented.
- Wrap: redirect to 62, id_ready=1: if_pc sequence 62, 63, 0, 1.
- Reset mid-run: reset=0 for one edge while if_valid=1 and stalled: if_valid=0, stall_count=0, imem_address=0; restart behaves as startup.
- Saturation: id_ready=0 for 65540 cycles with if_valid=1: stall_count=16'hFFFF and stays.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem,
// and hands instructions to decode over a valid/ready handshake.
module instruction_fetch #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [15:0]       stall_count
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rsp_q, rsp_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [15:0]       cnt_q, cnt_d;

  logic xfer;
  logic load;
  logic stall;

  assign xfer  = vld_q && id_ready;
  assign stall = vld_q && !id_ready;
  assign load  = rsp_q && (!vld_q || id_ready)
              && !redirect_valid;

  // Address select, PC advance and output register load.
  always_comb begin
    pc_d         = pc_q;
    rsp_d        = rsp_q;
    vld_d        = vld_q;
    ins_d        = ins_q;
    ipc_d        = ipc_q;
    imem_address = pc_q;
    if (redirect_valid) begin
      imem_address = redirect_target;
      pc_d         = redirect_target;
      rsp_d        = 1'b1;
      vld_d        = 1'b0;
    end else if (!rsp_q) begin
      rsp_d = 1'b1;
      if (xfer) vld_d = 1'b0;
    end else if (load) begin
      imem_address = pc_q + ADDR_W'(1);
      pc_d         = pc_q + ADDR_W'(1);
      ins_d        = imem_data;
      ipc_d        = pc_q;
      vld_d        = 1'b1;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
    if (!reset) imem_address = RESET_PC;
  end

  // Saturating count of cycles decode holds off a valid instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      rsp_q <= 1'b0;
      vld_q <= 1'b0;
      ins_q <= '0;
      ipc_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rsp_q <= rsp_d;
      vld_q <= vld_d;
      ins_q <= ins_d;
      ipc_q <= ipc_d;
      cnt_q <= cnt_d;
    end
  end

  assign if_valid    = vld_q;
  assign if_instr    = ins_q;
  assign if_pc       = ipc_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed plan checks plus random
// handshake/redirect/reset traffic against a delivery-level model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  imem_address;
  logic [31:0] imem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_target = '0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_pc;
  logic [15:0] stall_count;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  instruction_fetch dut (
    .clk(clk),
    .reset(reset),
    .imem_address(imem_address),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .id_ready(id_ready),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(logic [5:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // synchronous memory: data one edge after the address
  always @(posedge clk) imem_data <= memw(imem_address);

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what decode sees, and which PC it will be offered next.
  bit         m_valid = 0;
  logic [5:0] m_pc = 0;
  logic [31:0] m_instr = 0;
  logic [5:0] m_next = 0;
  bit         m_primed = 0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid = 0; m_pc = 0; m_instr = 0;
      m_next = 0; m_primed = 0; m_cnt = 0;
    end else begin
      if (m_valid && !id_ready && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (redirect_valid) begin
        m_valid = 0;
        m_next = redirect_target;
        m_primed = 1;
      end else if (!m_primed) begin
        m_primed = 1;
        if (m_valid && id_ready) m_valid = 0;
      end else if (!m_valid || id_ready) begin
        m_valid = 1;
        m_pc = m_next;
        m_instr = memw(m_next);
        m_next = m_next + 6'd1;
      end
    end
  end

  function automatic logic [5:0] exp_addr();
    if (!reset) return 6'd0;
    if (redirect_valid) return redirect_target;
    if (!m_primed) return m_next;
    if (m_valid && !id_ready) return m_next;
    return m_next + 6'd1;
  endfunction

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
        check("pc", 32'(if_pc), 32'(m_pc));
        check("instr", if_instr, m_instr);
      end
      check("stallcnt", 32'(stall_count), 32'(m_cnt));
      check("addr", 32'(imem_address), 32'(exp_addr()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; id_ready = 1; redirect_valid = 0;
    repeat (3) cyc();
    chk_en = 1;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_addr", 32'(imem_address), 32'd0);
    reset = 1;
    cyc();
    cyc();
    check("start_valid", 32'(if_valid), 32'd1);
    check("start_pc", 32'(if_pc), 32'd0);
    check("start_instr", if_instr, 32'hA000_0000);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("seq_pc", 32'(if_pc), 32'(k));
    end
    id_ready = 0;
    #1;
    check("stall_addr0", 32'(imem_address), 32'd5);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_pc", 32'(if_pc), 32'd4);
      check("stall_instr", if_instr, 32'hA000_0004);
      check("stall_addr", 32'(imem_address), 32'd5);
    end
    check("stall_cnt3", 32'(stall_count), 32'd3);
    id_ready = 1;
    cyc();
    check("rel_pc5", 32'(if_pc), 32'd5);
    cyc();
    check("rel_pc6", 32'(if_pc), 32'd6);
    cyc();
    check("pre_redir_pc7", 32'(if_pc), 32'd7);
    redirect_valid = 1; redirect_target = 6'd40;
    cyc();
    redirect_valid = 0;
    check("bubble", 32'(if_valid), 32'd0);
    cyc();
    check("redir_pc40", 32'(if_pc), 32'd40);
    check("redir_v", 32'(if_valid), 32'd1);
    cyc();
    check("redir_pc41", 32'(if_pc), 32'd41);
    redirect_valid = 1; redirect_target = 6'd62;
    cyc();
    redirect_valid = 0;
    cyc();
    check("wrap62", 32'(if_pc), 32'd62);
    cyc();
    check("wrap63", 32'(if_pc), 32'd63);
    cyc();
    check("wrap0", 32'(if_pc), 32'd0);
    check("wrap0_instr", if_instr, 32'hA000_0000);
    cyc();
    check("wrap1", 32'(if_pc), 32'd1);
    id_ready = 0;
    cyc();
    cyc();
    reset = 0;
    #1;
    check("mrst_addr", 32'(imem_address), 32'd0);
    cyc();
    check("mrst_valid", 32'(if_valid), 32'd0);
    check("mrst_cnt", 32'(stall_count), 32'd0);
    reset = 1; id_ready = 1;
    cyc();
    cyc();
    check("restart_pc", 32'(if_pc), 32'd0);
    check("restart_v", 32'(if_valid), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      id_ready = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 10);
      redirect_target = 6'($urandom);
      reset = ($urandom_range(199) != 0);
      cyc();
    end
    reset = 1; redirect_valid = 0; id_ready = 1;
    repeat (3) cyc();
    id_ready = 0;
    repeat (65540) cyc();
    check("sat", 32'(stall_count), 32'hFFFF);
    repeat (4) cyc();
    check("sat_hold", 32'(stall_count), 32'hFFFF);
    check("sat_valid", 32'(if_valid), 32'd1);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
